// File: rtl/nn_pkg.sv
// Shared parameter defaults and the argmax FSM state type for the NN output stage.
package nn_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_NUM_CLASSES = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Signed strict-greater compare and select between the running maximum and a candidate score.
module argmax_cmp #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 4
) (
  input  logic signed [DATA_WIDTH-1:0] cur_max,
  input  logic        [IDX_W-1:0]      cur_idx,
  input  logic signed [DATA_WIDTH-1:0] cand_val,
  input  logic        [IDX_W-1:0]      cand_idx,
  output logic signed [DATA_WIDTH-1:0] sel_max,
  output logic        [IDX_W-1:0]      sel_idx
);

  logic take;

  // Strict greater-than keeps the earlier (lower) index on ties.
  assign take    = (cand_val > cur_max);
  assign sel_max = take ? cand_val : cur_max;
  assign sel_idx = take ? cand_idx : cur_idx;

endmodule

// File: rtl/argmax_classifier.sv
// Streams NUM_CLASSES signed scores per frame and holds the index/value of the maximum
// until the consumer accepts it.
module argmax_classifier
  import nn_pkg::*;
#(
  parameter int NUM_CLASSES = DEFAULT_NUM_CLASSES,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  localparam int IDX_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [IDX_W-1:0]      class_idx,
  output logic signed [DATA_WIDTH-1:0] max_val,
  output logic                         frame_err
);

  localparam int              CNT_W      = $clog2(NUM_CLASSES + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_CLASSES);

  argmax_state_t state, state_next;

  logic        [CNT_W-1:0]      count;
  logic        [CNT_W-1:0]      beats_next;
  logic                         accept;
  logic                         closing;
  logic signed [DATA_WIDTH-1:0] sel_max;
  logic        [IDX_W-1:0]      sel_idx;

  assign in_ready   = (state != HOLD);
  assign out_valid  = (state == HOLD);
  assign accept     = in_valid && in_ready;
  assign beats_next = count + 1'b1;
  // A frame closes on in_last or when the full class count has arrived, whichever comes first.
  assign closing    = in_last || (beats_next == FULL_COUNT);

  argmax_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_cmp (
    .cur_max  (max_val),
    .cur_idx  (class_idx),
    .cand_val (in_data),
    .cand_idx (count[IDX_W-1:0]),
    .sel_max  (sel_max),
    .sel_idx  (sel_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, COLLECT: begin
        if (accept) state_next = closing ? HOLD : COLLECT;
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The first beat of a frame loads unconditionally so stale results never leak into a new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      class_idx <= '0;
      max_val   <= '0;
      frame_err <= 1'b0;
    end else if (accept) begin
      count <= beats_next;
      if (state == IDLE) begin
        max_val   <= in_data;
        class_idx <= '0;
      end else begin
        max_val   <= sel_max;
        class_idx <= sel_idx;
      end
      if (closing) frame_err <= !in_last || (beats_next != FULL_COUNT);
    end else if ((state == HOLD) && out_ready) begin
      count     <= '0;
      frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// Randomized self-checking bench for argmax_classifier against a plain argmax reference model.
module tb_argmax_classifier;

  localparam int N  = 10;
  localparam int W  = 16;
  localparam int IW = $clog2(N);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic signed [W-1:0] in_data = '0;
  logic                in_last = 1'b0;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [IW-1:0]       class_idx;
  logic signed [W-1:0] max_val;
  logic                frame_err;

  int checks   = 0;
  int failures = 0;

  logic signed [W-1:0] vals [0:N-1];
  logic [IW-1:0]       e_idx;
  logic signed [W-1:0] e_max;
  logic                e_err;
  bit                  timed_out;
  bit                  early_valid;

  argmax_classifier #(.NUM_CLASSES(N), .DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .class_idx (class_idx),
    .max_val   (max_val),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Reference: argmax over the beats the frame actually contains, first occurrence wins.
  function automatic void model(input int len, input bit has_last,
                                output logic [IW-1:0] idx, output logic signed [W-1:0] mx,
                                output logic err);
    int k;
    k   = has_last ? len : N;
    err = !has_last || (len != N);
    mx  = vals[0];
    idx = '0;
    for (int i = 1; i < k; i++) begin
      if (vals[i] > mx) begin
        mx  = vals[i];
        idx = IW'(i);
      end
    end
  endfunction

  task automatic fill_random(input bit narrow);
    for (int i = 0; i < N; i++)
      vals[i] = narrow ? W'(int'($urandom_range(7)) - 4) : W'($urandom);
  endtask

  task automatic drive_beat(input logic signed [W-1:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) timed_out = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit has_last, input int bubble_pct);
    timed_out   = 1'b0;
    early_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (int'($urandom_range(99)) < bubble_pct) begin
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
      if (out_valid) early_valid = 1'b1;
      drive_beat(vals[i], has_last && (i == len - 1));
    end
  endtask

  task automatic release_result();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, class_idx, max_val, frame_err} !== {1'b0, IW'(0), W'(0), 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_state: got valid=%0b idx=%0d max=%0d err=%0b, want all zero",
               out_valid, class_idx, max_val, frame_err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready: got in_ready=%0b, want 1", in_ready);
    end
  endtask

  task automatic test_known_frame();
    int tbl [N] = '{3, -7, 12, 5, 0, 1, 2, 9, -1, 4};
    for (int i = 0; i < N; i++) vals[i] = W'(tbl[i]);
    send_frame(N, 1'b1, 0);
    checks++;
    if (timed_out || early_valid || out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL known_latency: got timeout=%0b early=%0b valid=%0b, want 0 0 1",
               timed_out, early_valid, out_valid);
    end
    checks++;
    if ({class_idx, max_val, frame_err} !== {IW'(2), W'(12), 1'b0}) begin
      failures++;
      $display("[TB] FAIL known_result: got idx=%0d max=%0d err=%0b, want idx=2 max=12 err=0",
               class_idx, max_val, frame_err);
    end
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL known_release: got valid=%0b ready=%0b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_ties_negative();
    for (int i = 0; i < N; i++) vals[i] = -W'(5);
    vals[4] = -W'(2);
    vals[7] = -W'(2);
    send_frame(N, 1'b1, 0);
    checks++;
    if (timed_out || {out_valid, class_idx, max_val, frame_err} !== {1'b1, IW'(4), -W'(2), 1'b0}) begin
      failures++;
      $display("[TB] FAIL tie_result: got valid=%0b idx=%0d max=%0d err=%0b, want 1 4 -2 0",
               out_valid, class_idx, max_val, frame_err);
    end
    release_result();
  endtask

  task automatic test_short_frame();
    fill_random(1'b0);
    out_ready = 1'b1;
    send_frame(6, 1'b1, 0);
    model(6, 1'b1, e_idx, e_max, e_err);
    checks++;
    if (timed_out || early_valid ||
        {out_valid, class_idx, max_val, frame_err} !== {1'b1, e_idx, e_max, e_err}) begin
      failures++;
      $display("[TB] FAIL short_frame: got valid=%0b idx=%0d max=%0d err=%0b, want 1 %0d %0d %0b",
               out_valid, class_idx, max_val, frame_err, e_idx, e_max, e_err);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL short_release: got valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_overlong_frame();
    logic [IW-1:0]       s_idx;
    logic signed [W-1:0] s_max;
    bit                  moved;
    fill_random(1'b0);
    send_frame(N, 1'b0, 0);
    model(N, 1'b0, e_idx, e_max, e_err);
    checks++;
    if (timed_out || {out_valid, in_ready, class_idx, max_val, frame_err} !==
                     {1'b1, 1'b0, e_idx, e_max, e_err}) begin
      failures++;
      $display("[TB] FAIL overlong: got valid=%0b ready=%0b idx=%0d max=%0d err=%0b, want 1 0 %0d %0d %0b",
               out_valid, in_ready, class_idx, max_val, frame_err, e_idx, e_max, e_err);
    end
    s_idx = class_idx;
    s_max = max_val;
    moved = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'sh7fff;
    in_last  = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (in_ready || !out_valid || class_idx !== s_idx || max_val !== s_max || !frame_err) moved = 1'b1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (moved) begin
      failures++;
      $display("[TB] FAIL overlong_extra_beat: got result disturbed=1, want 0");
    end
    release_result();
  endtask

  task automatic test_hold_stall();
    logic [IW-1:0]       s_idx;
    logic signed [W-1:0] s_max;
    int                  bad;
    fill_random(1'b0);
    send_frame(N, 1'b1, 0);
    model(N, 1'b1, e_idx, e_max, e_err);
    s_idx = class_idx;
    s_max = max_val;
    bad = 0;
    in_valid = 1'b1;
    in_data  = W'($urandom);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (in_ready || !out_valid || class_idx !== s_idx || max_val !== s_max || frame_err) bad++;
    end
    checks++;
    if (bad != 0 || s_idx !== e_idx || s_max !== e_max) begin
      failures++;
      $display("[TB] FAIL hold_stall: got bad_cycles=%0d idx=%0d max=%0d, want 0 %0d %0d",
               bad, s_idx, s_max, e_idx, e_max);
    end
    release_result();
    fill_random(1'b1);
    send_frame(N, 1'b1, 0);
    model(N, 1'b1, e_idx, e_max, e_err);
    checks++;
    if (timed_out || {out_valid, class_idx, max_val, frame_err} !== {1'b1, e_idx, e_max, e_err}) begin
      failures++;
      $display("[TB] FAIL hold_next_frame: got valid=%0b idx=%0d max=%0d err=%0b, want 1 %0d %0d %0b",
               out_valid, class_idx, max_val, frame_err, e_idx, e_max, e_err);
    end
    release_result();
  endtask

  task automatic test_reset_midframe();
    int seen;
    fill_random(1'b0);
    send_frame(5, 1'b0, 0);
    rst = 1'b1;
    #2;
    checks++;
    if ({out_valid, class_idx, max_val, frame_err} !== {1'b0, IW'(0), W'(0), 1'b0}) begin
      failures++;
      $display("[TB] FAIL midframe_reset: got valid=%0b idx=%0d max=%0d err=%0b, want all zero",
               out_valid, class_idx, max_val, frame_err);
    end
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midframe_no_result: got valid_cycles=%0d ready=%0b, want 0 1", seen, in_ready);
    end
    for (int i = 0; i < N; i++) vals[i] = 16'sh8000;
    vals[9] = 16'sh7fff;
    send_frame(N, 1'b1, 0);
    checks++;
    if (timed_out || {out_valid, class_idx, max_val, frame_err} !== {1'b1, IW'(9), 16'sh7fff, 1'b0}) begin
      failures++;
      $display("[TB] FAIL extremes: got valid=%0b idx=%0d max=%0h err=%0b, want 1 9 7fff 0",
               out_valid, class_idx, max_val, frame_err);
    end
    release_result();
  endtask

  task automatic test_bubbles();
    logic [IW-1:0]       r_idx;
    logic signed [W-1:0] r_max;
    logic                r_err;
    for (int f = 0; f < 4; f++) begin
      fill_random(f[0]);
      model(N, 1'b1, e_idx, e_max, e_err);
      send_frame(N, 1'b1, 0);
      r_idx = class_idx;
      r_max = max_val;
      r_err = frame_err;
      release_result();
      send_frame(N, 1'b1, 60);
      checks++;
      if (timed_out || {out_valid, class_idx, max_val, frame_err} !== {1'b1, e_idx, e_max, e_err} ||
          {r_idx, r_max, r_err} !== {e_idx, e_max, e_err}) begin
        failures++;
        $display("[TB] FAIL bubbles_%0d: got stream=%0d/%0d/%0b bubbled=%0d/%0d/%0b, want %0d/%0d/%0b",
                 f, r_idx, r_max, r_err, class_idx, max_val, frame_err, e_idx, e_max, e_err);
      end
      release_result();
    end
  endtask

  task automatic test_random_frames();
    int len;
    for (int f = 0; f < 12; f++) begin
      fill_random(f[0]);
      len = int'($urandom_range(N, 2));
      model(len, 1'b1, e_idx, e_max, e_err);
      send_frame(len, 1'b1, 30);
      checks++;
      if (timed_out || early_valid ||
          {out_valid, class_idx, max_val, frame_err} !== {1'b1, e_idx, e_max, e_err}) begin
        failures++;
        $display("[TB] FAIL random_%0d len=%0d: got valid=%0b idx=%0d max=%0d err=%0b, want 1 %0d %0d %0b",
                 f, len, out_valid, class_idx, max_val, frame_err, e_idx, e_max, e_err);
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_known_frame();
    test_ties_negative();
    test_short_frame();
    test_overlong_frame();
    test_hold_stall();
    test_reset_midframe();
    test_bubbles();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
